// File: rtl/lif_neuron_array_stepper_if.sv
// Weight-event input channel and spike-event output channel of the LIF neuron bank.
// The master side is the NoC packet decoder / spike encoder pair, the slave side is the bank.
interface lif_neuron_array_stepper_if #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [ID_W-1:0]   in_neuron_id;
   logic [DATA_W-1:0] in_weight;
   logic              spike_valid;
   logic [ID_W-1:0]   spike_id;
   logic [DATA_W-1:0] spike_potential;

   modport master (
      output in_valid, in_neuron_id, in_weight,
      input  in_ready, spike_valid, spike_id, spike_potential
   );

   modport slave (
      input  in_valid, in_neuron_id, in_weight,
      output in_ready, spike_valid, spike_id, spike_potential
   );
endinterface

// File: rtl/lif_neuron_array_stepper.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons.
// Weights are integrated while accumulating; step_start triggers one sweep over every
// neuron (refractory countdown, threshold/spike with reset-by-subtraction, leak).
module lif_neuron_array_stepper #(
   parameter int NUM_NEURONS = 20,
   parameter int DATA_W      = 16,
   parameter int ID_W        = 5,
   parameter int REFRAC_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   cfg_threshold,
   input  logic [3:0]          cfg_decay_shift,
   input  logic [REFRAC_W-1:0] cfg_refrac,
   lif_neuron_array_stepper_if.slave bus,
   input  logic                step_start,
   output logic                busy,
   output logic                done
);

   // The sweep index runs one past the last neuron; that extra slot is the wrap-up cycle
   // before the done pulse.
   localparam int IDX_W = $clog2(NUM_NEURONS + 1);

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [1:0]                state;
   logic [IDX_W-1:0]          idx;
   logic signed [DATA_W-1:0]  pot    [NUM_NEURONS];
   logic [REFRAC_W-1:0]       refrac [NUM_NEURONS];
   logic signed [DATA_W-1:0]  th_q;
   logic [3:0]                shift_q;
   logic [REFRAC_W-1:0]       refrac_q;

   logic                      in_ready_q;
   logic                      spike_valid_q;
   logic [ID_W-1:0]           spike_id_q;
   logic [DATA_W-1:0]         spike_potential_q;

   logic                      id_ok;
   logic                      accept;
   logic signed [DATA_W-1:0]  in_w;
   logic                      sweep_last;
   logic [IDX_W-1:0]          sel;
   logic signed [DATA_W-1:0]  cur_v;
   logic [REFRAC_W-1:0]       cur_r;
   logic signed [DATA_W-1:0]  cur_fired;
   logic signed [DATA_W-1:0]  cur_leaked;

   // Resolve a wide signed result back to DATA_W, clamping instead of wrapping.
   function automatic logic signed [DATA_W-1:0] sat_fit(input logic signed [DATA_W:0] s);
      if (s[DATA_W] != s[DATA_W-1])
         return s[DATA_W] ? SAT_MIN : SAT_MAX;
      return s[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      return sat_fit(s);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W:0] s;
      s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      return sat_fit(s);
   endfunction

   // A zero shift means no leak at all, not a full discharge; v - (v >>> s) cannot overflow
   // for s >= 1 because the subtracted term always has the same sign and smaller magnitude.
   function automatic logic signed [DATA_W-1:0] leak(input logic signed [DATA_W-1:0] v,
                                                     input logic [3:0] s);
      if (s == 4'd0)
         return v;
      return v - (v >>> s);
   endfunction

   assign bus.in_ready        = in_ready_q;
   assign bus.spike_valid     = spike_valid_q;
   assign bus.spike_id        = spike_id_q;
   assign bus.spike_potential = spike_potential_q;

   assign in_w       = $signed(bus.in_weight);
   assign id_ok      = int'(bus.in_neuron_id) < NUM_NEURONS;
   assign accept     = bus.in_valid && in_ready_q && id_ok;
   assign sweep_last = (idx == IDX_W'(NUM_NEURONS));

   // Select the neuron under the sweep; the wrap-up slot reads entry 0 harmlessly.
   always_comb begin
      sel        = sweep_last ? '0 : idx;
      cur_v      = pot[sel];
      cur_r      = refrac[sel];
      cur_fired  = sat_sub(cur_v, th_q);
      cur_leaked = leak(cur_v, shift_q);
   end

   // Controller and neuron state: integrate while accumulating, update one neuron per
   // sweep cycle, then emit a single done pulse before accepting weights again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_ACCUM;
         idx               <= '0;
         th_q              <= '0;
         shift_q           <= '0;
         refrac_q          <= '0;
         in_ready_q        <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         spike_valid_q     <= 1'b0;
         spike_id_q        <= '0;
         spike_potential_q <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot[i]    <= '0;
            refrac[i] <= '0;
         end
      end else begin
         spike_valid_q <= 1'b0;
         case (state)
            ST_ACCUM: begin
               in_ready_q <= 1'b1;
               done       <= 1'b0;
               if (accept && refrac[bus.in_neuron_id] == '0)
                  pot[bus.in_neuron_id] <= sat_add(pot[bus.in_neuron_id], in_w);
               if (step_start) begin
                  th_q       <= $signed(cfg_threshold);
                  shift_q    <= cfg_decay_shift;
                  refrac_q   <= cfg_refrac;
                  idx        <= '0;
                  state      <= ST_SWEEP;
                  busy       <= 1'b1;
                  in_ready_q <= 1'b0;
               end
            end
            ST_SWEEP: begin
               if (sweep_last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
                  if (cur_r != '0) begin
                     refrac[sel] <= cur_r - REFRAC_W'(1);
                     pot[sel]    <= cur_leaked;
                  end else if (cur_v >= th_q) begin
                     pot[sel]          <= cur_fired;
                     refrac[sel]       <= refrac_q;
                     spike_valid_q     <= 1'b1;
                     spike_id_q        <= ID_W'(idx);
                     spike_potential_q <= cur_fired;
                  end else begin
                     pot[sel] <= cur_leaked;
                  end
               end
            end
            ST_DONE: begin
               done       <= 1'b0;
               in_ready_q <= 1'b1;
               state      <= ST_ACCUM;
            end
            default: begin
               state <= ST_ACCUM;
            end
         endcase
      end
   end

endmodule
